// File: rtl/process_scheduler.sv
// Round-robin time-slice scheduler: tracks per-process saved PCs and forces PC loads
// on dispatch, quantum expiry and return to OS code.
module process_scheduler #(
   parameter int unsigned NPROC   = 4,
   parameter int unsigned IDW     = 2,
   parameter int unsigned PC_W    = 10,
   parameter int unsigned QUANTUM = 16
) (
   input  logic            clock_i,
   input  logic            reset_i,
   input  logic            create_en_i,
   input  logic [IDW-1:0]  create_id_i,
   input  logic [PC_W-1:0] create_pc_i,
   input  logic            exec_start_i,
   input  logic            end_proc_i,
   input  logic            halt_i,
   input  logic [PC_W-1:0] curr_pc_i,
   output logic            pc_load_o,
   output logic [PC_W-1:0] pc_load_val_o,
   output logic [IDW-1:0]  proc_id_o,
   output logic            os_mode_o,
   output logic            busy_o
);

   localparam int unsigned QW = $clog2(QUANTUM);
   localparam logic [QW-1:0] QLast = QW'(QUANTUM - 1);

   typedef enum logic [2:0] {StOs, StSelect, StLoad, StRun, StSave, StReturn} state_e;

   state_e                      state_q, state_d;
   logic [NPROC-1:0]            valid_q, valid_d;
   logic [NPROC-1:0][PC_W-1:0]  saved_pc_q, saved_pc_d;
   logic [PC_W-1:0]             os_pc_q, os_pc_d;
   logic [IDW-1:0]              last_id_q, last_id_d;
   logic [IDW-1:0]              proc_id_q, proc_id_d;
   logic [QW-1:0]               qcnt_q, qcnt_d;
   logic                        os_mode_q, os_mode_d;

   logic                        sel_hit;
   logic [IDW-1:0]              sel_id;

   // Search starts just after the last dispatched slot; i == NPROC wraps back onto it.
   always_comb begin
      sel_hit = 1'b0;
      sel_id  = last_id_q;
      for (int unsigned i = 1; i <= NPROC; i++) begin
         if (!sel_hit && valid_q[last_id_q + IDW'(i)]) begin
            sel_hit = 1'b1;
            sel_id  = last_id_q + IDW'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      saved_pc_d = saved_pc_q;
      os_pc_d    = os_pc_q;
      last_id_d  = last_id_q;
      proc_id_d  = proc_id_q;
      qcnt_d     = qcnt_q;
      os_mode_d  = os_mode_q;

      unique case (state_q)
         StOs: begin
            if (exec_start_i) begin
               os_pc_d = curr_pc_i + PC_W'(1);
               state_d = StSelect;
            end
         end
         StSelect: begin
            if (sel_hit) begin
               proc_id_d = sel_id;
               last_id_d = sel_id;
               state_d   = StLoad;
            end else begin
               state_d = StReturn;
            end
         end
         StLoad: begin
            qcnt_d    = '0;
            os_mode_d = 1'b0;
            state_d   = StRun;
         end
         StRun: begin
            if (end_proc_i) begin
               valid_d[proc_id_q] = 1'b0;
               state_d            = StSelect;
            end else if (!halt_i) begin
               qcnt_d = qcnt_q + QW'(1);
               if (qcnt_q == QLast) state_d = StSave;
            end
         end
         StSave:   state_d = StSelect;
         StReturn: begin
            os_mode_d = 1'b1;
            state_d   = StOs;
         end
         default:  state_d = StOs;
      endcase

      // Create overrides an end_proc clear; a SAVE write overrides create.
      if (create_en_i) begin
         valid_d[create_id_i]    = 1'b1;
         saved_pc_d[create_id_i] = create_pc_i;
      end
      if (state_q == StSave) saved_pc_d[proc_id_q] = curr_pc_i;
   end

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q    <= StOs;
         valid_q    <= '0;
         saved_pc_q <= '0;
         os_pc_q    <= '0;
         last_id_q  <= IDW'(NPROC - 1);
         proc_id_q  <= '0;
         qcnt_q     <= '0;
         os_mode_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         saved_pc_q <= saved_pc_d;
         os_pc_q    <= os_pc_d;
         last_id_q  <= last_id_d;
         proc_id_q  <= proc_id_d;
         qcnt_q     <= qcnt_d;
         os_mode_q  <= os_mode_d;
      end
   end

   always_comb begin
      pc_load_o     = 1'b0;
      pc_load_val_o = '0;
      busy_o        = 1'b0;
      unique case (state_q)
         StLoad: begin
            pc_load_o     = 1'b1;
            pc_load_val_o = saved_pc_q[proc_id_q];
            busy_o        = 1'b1;
         end
         StReturn: begin
            pc_load_o     = 1'b1;
            pc_load_val_o = os_pc_q;
            busy_o        = 1'b1;
         end
         StSave, StSelect: busy_o = 1'b1;
         default: ;
      endcase
   end

   assign proc_id_o = proc_id_q;
   assign os_mode_o = os_mode_q;

endmodule

// File: tb/tb_process_scheduler.sv
// Directed bench for process_scheduler: dispatch, expiry, end_proc, halt, reset and
// create/end_proc collision scenarios with hand-computed expectations.
module tb_process_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       create_en = 1'b0;
   logic [1:0] create_id = '0;
   logic [9:0] create_pc = '0;
   logic       exec_start = 1'b0;
   logic       end_proc = 1'b0;
   logic       halt = 1'b0;
   logic [9:0] curr_pc = '0;
   logic       pc_load;
   logic [9:0] pc_load_val;
   logic [1:0] proc_id;
   logic       os_mode;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int n;

   process_scheduler #(
      .NPROC(4), .IDW(2), .PC_W(10), .QUANTUM(16)
   ) dut (
      .clock_i      (clk),
      .reset_i      (reset),
      .create_en_i  (create_en),
      .create_id_i  (create_id),
      .create_pc_i  (create_pc),
      .exec_start_i (exec_start),
      .end_proc_i   (end_proc),
      .halt_i       (halt),
      .curr_pc_i    (curr_pc),
      .pc_load_o    (pc_load),
      .pc_load_val_o(pc_load_val),
      .proc_id_o    (proc_id),
      .os_mode_o    (os_mode),
      .busy_o       (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then stable and inputs may be changed.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   task automatic create(input logic [1:0] id, input logic [9:0] pc);
      create_en = 1'b1;
      create_id = id;
      create_pc = pc;
      step();
      create_en = 1'b0;
   endtask

   task automatic exec(input logic [9:0] pc);
      curr_pc    = pc;
      exec_start = 1'b1;
      step();
      exec_start = 1'b0;
   endtask

   // Steps until pc_load is seen; a stuck DUT shows up as count 200.
   task automatic wait_load(output int cnt);
      cnt = 0;
      step();
      cnt++;
      while (!pc_load && cnt < 200) begin
         step();
         cnt++;
      end
   endtask

   initial begin
      // 1: reset state, two-process rotation
      do_reset();
      check_eq("rst_pc_load", pc_load, 0);
      check_eq("rst_pc_val", pc_load_val, 0);
      check_eq("rst_proc_id", proc_id, 0);
      check_eq("rst_os_mode", os_mode, 1);
      check_eq("rst_busy", busy, 0);
      create(2'd0, 10'd40);
      create(2'd2, 10'd80);
      exec(10'd5);
      check_eq("t1_select_busy", busy, 1);
      check_eq("t1_select_noload", pc_load, 0);
      step();
      check_eq("t1_load", pc_load, 1);
      check_eq("t1_load_val", pc_load_val, 40);
      check_eq("t1_load_id", proc_id, 0);
      step();
      check_eq("t1_run_os_mode", os_mode, 0);
      check_eq("t1_run_busy", busy, 0);
      curr_pc = 10'd50;
      repeat (15) step();
      check_eq("t1_last_run_busy", busy, 0);
      step();
      check_eq("t1_save_busy", busy, 1);
      check_eq("t1_save_noload", pc_load, 0);
      step();
      step();
      check_eq("t1_load2", pc_load, 1);
      check_eq("t1_load2_val", pc_load_val, 80);
      check_eq("t1_load2_id", proc_id, 2);
      step();
      wait_load(n);
      check_eq("t1_slice_len", n, 18);
      check_eq("t1_load3_val", pc_load_val, 50);
      check_eq("t1_load3_id", proc_id, 0);

      // 2: single process re-selects itself with its saved PC
      do_reset();
      create(2'd1, 10'd12);
      exec(10'd9);
      step();
      check_eq("t2_load_val", pc_load_val, 12);
      check_eq("t2_load_id", proc_id, 1);
      step();
      curr_pc = 10'd30;
      wait_load(n);
      check_eq("t2_slice_len", n, 18);
      check_eq("t2_reload_val", pc_load_val, 30);
      check_eq("t2_reload_id", proc_id, 1);

      // 3: end_proc on the expiry cycle, no other slots -> RETURN
      do_reset();
      create(2'd1, 10'd12);
      exec(10'd5);
      step();
      step();
      repeat (15) step();
      end_proc = 1'b1;
      step();
      end_proc = 1'b0;
      check_eq("t3_select_noload", pc_load, 0);
      step();
      check_eq("t3_return_load", pc_load, 1);
      check_eq("t3_return_val", pc_load_val, 6);
      check_eq("t3_return_busy", busy, 1);
      step();
      check_eq("t3_os_mode", os_mode, 1);
      check_eq("t3_os_busy", busy, 0);
      check_eq("t3_os_noload", pc_load, 0);

      // 4: halt freezes the quantum for exactly 10 cycles
      do_reset();
      create(2'd0, 10'd100);
      exec(10'd0);
      step();
      step();
      curr_pc = 10'd77;
      repeat (3) step();
      halt = 1'b1;
      repeat (10) step();
      halt = 1'b0;
      wait_load(n);
      check_eq("t4_remaining", n, 15);
      check_eq("t4_reload_val", pc_load_val, 77);

      // 5: reset during SAVE
      do_reset();
      create(2'd2, 10'd20);
      exec(10'd3);
      step();
      step();
      repeat (15) step();
      step();
      check_eq("t5_in_save", busy, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_eq("t5_rst_os_mode", os_mode, 1);
      check_eq("t5_rst_noload", pc_load, 0);
      check_eq("t5_rst_busy", busy, 0);
      check_eq("t5_rst_id", proc_id, 0);
      exec(10'd200);
      step();
      check_eq("t5_return_load", pc_load, 1);
      check_eq("t5_return_val", pc_load_val, 201);

      // 6: create and end_proc on the same slot in the same cycle
      do_reset();
      create(2'd3, 10'd60);
      exec(10'd1);
      step();
      check_eq("t6_load_val", pc_load_val, 60);
      check_eq("t6_load_id", proc_id, 3);
      step();
      repeat (4) step();
      end_proc  = 1'b1;
      create_en = 1'b1;
      create_id = 2'd3;
      create_pc = 10'd90;
      step();
      end_proc  = 1'b0;
      create_en = 1'b0;
      step();
      check_eq("t6_reload", pc_load, 1);
      check_eq("t6_reload_val", pc_load_val, 90);
      check_eq("t6_reload_id", proc_id, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
